// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
package keypad_pkg;

  localparam int unsigned KP_ROWS = 4;
  localparam int unsigned KP_COLS = 4;

  typedef logic [3:0] key_code_t;

  typedef enum logic [1:0] {
    FR_NONE  = 2'd0,
    FR_ONE   = 2'd1,
    FR_MULTI = 2'd2
  } frame_kind_t;

  typedef enum logic {
    KP_IDLE    = 1'b0,
    KP_PRESSED = 1'b1
  } kp_state_t;

  // Number of set bits in a column vector.
  function automatic logic [2:0] popcount4(logic [3:0] v);
    popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  // Index of the lowest set bit; only meaningful when exactly one bit is set.
  function automatic logic [1:0] first_set4(logic [3:0] v);
    first_set4 = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) first_set4 = 2'(i);
    end
  endfunction

endpackage

// File: rtl/matrix_key_scanner_if.sv
// Keypad pins plus decoded key outputs of the matrix key scanner.
interface matrix_key_scanner_if;
  import keypad_pkg::*;

  logic [3:0] col_n;
  logic [3:0] row_n;
  key_code_t  key_code;
  logic       key_held;
  logic       key_valid;
  logic       key_release;

  // Scanner side: reads columns, drives rows and key outputs.
  modport master (
    input  col_n,
    output row_n,
    output key_code,
    output key_held,
    output key_valid,
    output key_release
  );

  // Keypad/consumer side.
  modport slave (
    output col_n,
    input  row_n,
    input  key_code,
    input  key_held,
    input  key_valid,
    input  key_release
  );

endinterface

// File: rtl/key_frame_debouncer.sv
// Debounces complete scan-frame results and runs the stable key FSM.
module key_frame_debouncer
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_done,
  input  frame_kind_t frame_kind,
  input  key_code_t   frame_code,
  output key_code_t   key_code,
  output logic        key_held,
  output logic        key_valid,
  output logic        key_release
);

  localparam logic [3:0] DebMax = 4'(DEBOUNCE_FRAMES);

  frame_kind_t cand_kind_q;
  key_code_t   cand_code_q;
  logic [3:0]  match_q;
  logic [3:0]  match_d;
  logic        cand_match;
  kp_state_t   state_q;
  key_code_t   key_code_q;
  logic        key_held_q;
  logic        key_valid_q;
  logic        key_release_q;

  // Compare the frame to the candidate and compute the next match count.
  always_comb begin
    cand_match = (frame_kind == cand_kind_q) &&
                 ((frame_kind != FR_ONE) || (frame_code == cand_code_q));
    match_d = match_q;
    if (frame_kind == FR_MULTI) begin
      match_d = 4'd0;
    end else if (cand_match) begin
      match_d = (match_q == DebMax) ? match_q : match_q + 4'd1;
    end else begin
      match_d = 4'd1;
    end
  end

  // Candidate tracking plus stable FSM with registered outputs and strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_kind_q   <= FR_NONE;
      cand_code_q   <= '0;
      match_q       <= '0;
      state_q       <= KP_IDLE;
      key_code_q    <= '0;
      key_held_q    <= 1'b0;
      key_valid_q   <= 1'b0;
      key_release_q <= 1'b0;
    end else begin
      key_valid_q   <= 1'b0;
      key_release_q <= 1'b0;
      if (frame_done) begin
        match_q <= match_d;
        if (frame_kind != FR_MULTI && !cand_match) begin
          cand_kind_q <= frame_kind;
          cand_code_q <= frame_code;
        end
        // After the update the candidate equals frame_kind/frame_code.
        if (frame_kind != FR_MULTI && match_d == DebMax) begin
          case (state_q)
            KP_IDLE: begin
              if (frame_kind == FR_ONE) begin
                state_q     <= KP_PRESSED;
                key_code_q  <= frame_code;
                key_held_q  <= 1'b1;
                key_valid_q <= 1'b1;
              end
            end
            KP_PRESSED: begin
              if (frame_kind == FR_NONE) begin
                state_q       <= KP_IDLE;
                key_held_q    <= 1'b0;
                key_release_q <= 1'b1;
              end else if (frame_code != key_code_q) begin
                // Direct key change: new code, no release in between.
                key_code_q  <= frame_code;
                key_valid_q <= 1'b1;
              end
            end
            default: state_q <= KP_IDLE;
          endcase
        end
      end
    end
  end

  assign key_code    = key_code_q;
  assign key_held    = key_held_q;
  assign key_valid   = key_valid_q;
  assign key_release = key_release_q;

endmodule

// File: rtl/matrix_key_scanner.sv
// 4x4 active-low keypad scanner: row drive, column sync, frame accumulation.
module matrix_key_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned F_CLK           = 50000000,
  parameter int unsigned F_SCAN          = 1000,
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input logic                  clk,
  input logic                  rst,
  matrix_key_scanner_if.master kp
);

  localparam int unsigned TickMax = F_CLK / F_SCAN - 1;
  localparam int unsigned TickW   = (TickMax > 0) ? $clog2(TickMax + 1) : 1;

  logic [3:0]       col_meta_q;
  logic [3:0]       col_sync_q;
  logic [TickW-1:0] tick_cnt_q;
  logic             tick;
  logic [1:0]       row_idx_q;
  // 0: no contact so far, 1: one contact, 2: two or more.
  logic [1:0]       low_acc_q;
  key_code_t        acc_code_q;

  logic [3:0]  col_low;
  logic [2:0]  row_pop;
  logic [2:0]  low_sum;
  logic [1:0]  frame_low;
  key_code_t   acc_code_d;
  logic        frame_done;
  frame_kind_t frame_kind;

  // Two-flop synchronizer for the asynchronous column inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta_q <= 4'hF;
      col_sync_q <= 4'hF;
    end else begin
      col_meta_q <= kp.col_n;
      col_sync_q <= col_meta_q;
    end
  end

  // Row-step tick generator.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + 1'b1;
    end
  end

  assign tick = (tick_cnt_q == TickW'(TickMax));

  // Fold the current row's sample into the running frame result.
  always_comb begin
    col_low    = ~col_sync_q;
    row_pop    = popcount4(col_low);
    low_sum    = {1'b0, low_acc_q} + row_pop;
    frame_low  = (low_sum >= 3'd2) ? 2'd2 : low_sum[1:0];
    acc_code_d = (low_acc_q == 2'd0 && row_pop == 3'd1) ? {row_idx_q, first_set4(col_low)}
                                                         : acc_code_q;
    frame_done = tick && (row_idx_q == 2'd3);
    unique case (frame_low)
      2'd0:    frame_kind = FR_NONE;
      2'd1:    frame_kind = FR_ONE;
      default: frame_kind = FR_MULTI;
    endcase
  end

  // Sample on tick, advance the row, restart accumulation after row 3.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_idx_q  <= 2'd0;
      low_acc_q  <= 2'd0;
      acc_code_q <= '0;
    end else if (tick) begin
      row_idx_q <= row_idx_q + 2'd1;
      if (row_idx_q == 2'd3) begin
        low_acc_q  <= 2'd0;
        acc_code_q <= '0;
      end else begin
        low_acc_q  <= frame_low;
        acc_code_q <= acc_code_d;
      end
    end
  end

  assign kp.row_n = ~(4'b0001 << row_idx_q);

  key_code_t key_code;
  logic      key_held;
  logic      key_valid;
  logic      key_release;

  key_frame_debouncer #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_debouncer (
    .clk        (clk),
    .rst        (rst),
    .frame_done (frame_done),
    .frame_kind (frame_kind),
    .frame_code (acc_code_d),
    .key_code   (key_code),
    .key_held   (key_held),
    .key_valid  (key_valid),
    .key_release(key_release)
  );

  assign kp.key_code    = key_code;
  assign kp.key_held    = key_held;
  assign kp.key_valid   = key_valid;
  assign kp.key_release = key_release;

endmodule

// File: tb/tb_matrix_key_scanner.sv
// Directed bench for matrix_key_scanner with a behavioural keypad model.
module tb_matrix_key_scanner;

  localparam int unsigned F_CLK  = 1000;
  localparam int unsigned F_SCAN = 100;
  localparam int unsigned DEB    = 2;
  localparam int          SETTLE = 130;  // > 3 frames of 40 cycles

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] keys = 16'h0;
  logic [3:0]  col;

  matrix_key_scanner_if kp_if ();

  matrix_key_scanner #(
    .F_CLK          (F_CLK),
    .F_SCAN         (F_SCAN),
    .DEBOUNCE_FRAMES(DEB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp (kp_if)
  );

  always #5 clk = ~clk;

  // Keypad: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !kp_if.row_n[r]) col[c] = 1'b0;
      end
    end
    kp_if.col_n = col;
  end

  int        valid_cnt = 0;
  int        rel_cnt   = 0;
  int        both_cnt  = 0;
  logic [3:0] last_code = 4'h0;

  always @(negedge clk) begin
    if (kp_if.key_valid) begin
      valid_cnt <= valid_cnt + 1;
      last_code <= kp_if.key_code;
    end
    if (kp_if.key_release) rel_cnt <= rel_cnt + 1;
    if (kp_if.key_valid && kp_if.key_release) both_cnt <= both_cnt + 1;
  end

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  int         v0, r0, waited;
  logic [3:0] prev_row, cur_row;

  initial begin
    // Reset state.
    cycles(3);
    check("rst_row_n", 32'(kp_if.row_n), 32'hE);
    check("rst_key_code", 32'(kp_if.key_code), 32'h0);
    check("rst_held", 32'(kp_if.key_held), 32'h0);
    check("rst_valid", 32'(kp_if.key_valid), 32'h0);
    check("rst_release", 32'(kp_if.key_release), 32'h0);
    rst = 1'b0;

    // Idle: row rotation with a 10-cycle step.
    prev_row = kp_if.row_n;
    waited = 0;
    while (kp_if.row_n == prev_row && waited < 20) begin
      cycles(1);
      waited++;
    end
    check("row_first_step", 32'(waited < 20), 32'h1);
    check("row_after_first", 32'(kp_if.row_n), 32'hD);
    for (int i = 0; i < 4; i++) begin
      cur_row = kp_if.row_n;
      cycles(10);
      check("row_rotate", 32'(kp_if.row_n), 32'({cur_row[2:0], cur_row[3]}));
    end
    cycles(160);
    check("idle_valid", 32'(valid_cnt), 32'h0);
    check("idle_release", 32'(rel_cnt), 32'h0);
    check("idle_held", 32'(kp_if.key_held), 32'h0);

    // Key 9 (row 2, col 1) held for 5 frames.
    keys = 16'h0200;
    cycles(SETTLE);
    check("k9_valid_early", 32'(valid_cnt), 32'h1);
    cycles(200 - SETTLE);
    check("k9_valid_once", 32'(valid_cnt), 32'h1);
    check("k9_code", 32'(last_code), 32'h9);
    check("k9_held", 32'(kp_if.key_held), 32'h1);
    check("k9_no_release", 32'(rel_cnt), 32'h0);
    keys = 16'h0;
    cycles(SETTLE);
    check("k9_release", 32'(rel_cnt), 32'h1);
    check("k9_code_hold", 32'(kp_if.key_code), 32'h9);
    check("k9_held_off", 32'(kp_if.key_held), 32'h0);

    // One-frame bounce: exactly one row-2 sample sees the contact.
    v0 = valid_cnt;
    r0 = rel_cnt;
    keys = 16'h0200;
    cycles(40);
    keys = 16'h0;
    cycles(200);
    check("bounce_valid", 32'(valid_cnt - v0), 32'h0);
    check("bounce_release", 32'(rel_cnt - r0), 32'h0);
    check("bounce_held", 32'(kp_if.key_held), 32'h0);

    // Keys 0 and 15 together, then drop 15.
    v0 = valid_cnt;
    keys = 16'h8001;
    cycles(200);
    check("multi_valid", 32'(valid_cnt - v0), 32'h0);
    check("multi_held", 32'(kp_if.key_held), 32'h0);
    keys = 16'h0001;
    cycles(SETTLE);
    check("multi_to_one_valid", 32'(valid_cnt - v0), 32'h1);
    check("multi_to_one_code", 32'(last_code), 32'h0);
    check("multi_to_one_held", 32'(kp_if.key_held), 32'h1);
    keys = 16'h0;
    cycles(SETTLE);

    // Key 5 then key 6 with no empty frame.
    v0 = valid_cnt;
    r0 = rel_cnt;
    keys = 16'h0020;
    cycles(SETTLE);
    check("k5_valid", 32'(valid_cnt - v0), 32'h1);
    check("k5_code", 32'(last_code), 32'h5);
    keys = 16'h0040;
    cycles(SETTLE);
    check("k6_valid", 32'(valid_cnt - v0), 32'h2);
    check("k6_code", 32'(last_code), 32'h6);
    check("k6_no_release", 32'(rel_cnt - r0), 32'h0);
    check("k6_held", 32'(kp_if.key_held), 32'h1);
    keys = 16'h0;
    cycles(SETTLE);
    check("k6_release", 32'(rel_cnt - r0), 32'h1);

    // Reset while key 10 is held.
    keys = 16'h0400;
    cycles(SETTLE);
    check("k10_held", 32'(kp_if.key_held), 32'h1);
    check("k10_code", 32'(kp_if.key_code), 32'hA);
    v0 = valid_cnt;
    r0 = rel_cnt;
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    check("mid_rst_row_n", 32'(kp_if.row_n), 32'hE);
    check("mid_rst_code", 32'(kp_if.key_code), 32'h0);
    check("mid_rst_held", 32'(kp_if.key_held), 32'h0);
    check("mid_rst_valid", 32'(kp_if.key_valid), 32'h0);
    check("mid_rst_release", 32'(kp_if.key_release), 32'h0);
    cycles(SETTLE);
    check("k10_revalid", 32'(valid_cnt - v0), 32'h1);
    check("k10_revalid_code", 32'(last_code), 32'hA);
    check("k10_no_release", 32'(rel_cnt - r0), 32'h0);
    check("k10_reheld", 32'(kp_if.key_held), 32'h1);
    keys = 16'h0;
    cycles(SETTLE);

    check("never_both", 32'(both_cnt), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
